// File: rtl/cortex_m0_pkg.sv
// Shared types and Thumb-2 length decode for the cortex-m0 fetch stage.
// The queue depth is fixed at four halfwords.
package cortex_m0_pkg;

   localparam int QDEPTH = 4;

   // Issue only while two free slots remain, so a full word can always land.
   localparam logic [2:0] ISSUE_MAX = 3'(QDEPTH - 2);

   localparam logic [4:0] THUMB32_PREFIX_A = 5'b11101;
   localparam logic [4:0] THUMB32_PREFIX_B = 5'b11110;
   localparam logic [4:0] THUMB32_PREFIX_C = 5'b11111;

   typedef enum logic {
      FETCH   = 1'b0,
      DISCARD = 1'b1
   } fetch_state_e;

   function automatic logic is_thumb32(input logic [15:0] hw);
      return (hw[15:11] == THUMB32_PREFIX_A) ||
             (hw[15:11] == THUMB32_PREFIX_B) ||
             (hw[15:11] == THUMB32_PREFIX_C);
   endfunction

endpackage

// File: rtl/cortex_m0_fetch_if.sv
// Bundles the fetch stage's memory, branch and decode handshakes.
interface cortex_m0_fetch_if;
   // Handshakes:
   // - imem_req/imem_ack: the request and its address hold until the ack cycle.
   //   imem_rdata is valid only in that cycle, and at most one request is outstanding.
   // - inst_valid/dec_ready: the instruction moves on any cycle where both are high,
   //   unless branch_valid is high. A held instruction stays stable.
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        branch_valid;
   logic [31:0] branch_target;
   logic        inst_valid;
   logic [31:0] inst;
   logic        inst_is32;
   logic [31:0] inst_pc;
   logic        dec_ready;

   modport master (
      output imem_req, imem_addr, inst_valid, inst, inst_is32, inst_pc,
      input  imem_ack, imem_rdata, branch_valid, branch_target, dec_ready
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst, inst_is32, inst_pc,
      output imem_ack, imem_rdata, branch_valid, branch_target, dec_ready
   );
endinterface

// File: rtl/cortex_m0_fetch_queue.sv
// A four-entry circular halfword FIFO. Each cycle it can push one or two
// entries and pop one or two; flush clears it.
module cortex_m0_fetch_queue (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic [1:0]  push_n,
   input  logic [15:0] push_lo,
   input  logic [15:0] push_hi,
   input  logic [1:0]  pop_n,
   output logic [2:0]  count,
   output logic [15:0] head,
   output logic [15:0] head_next
);

   logic [15:0] mem [4];
   logic [1:0]  rd_ptr;
   logic [1:0]  wr_ptr;

   assign head      = mem[rd_ptr];
   assign head_next = mem[rd_ptr + 2'd1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= 2'd0;
         wr_ptr <= 2'd0;
         count  <= 3'd0;
         for (int i = 0; i < 4; i++) mem[i] <= 16'h0;
      end else if (flush) begin
         rd_ptr <= 2'd0;
         wr_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push_n != 2'd0) mem[wr_ptr] <= push_lo;
         if (push_n == 2'd2) mem[wr_ptr + 2'd1] <= push_hi;
         wr_ptr <= wr_ptr + push_n;
         rd_ptr <= rd_ptr + pop_n;
         count  <= count + {1'b0, push_n} - {1'b0, pop_n};
      end
   end

endmodule

// File: rtl/cortex_m0_fetch.sv
// Cortex-m0 fetch stage. It fills a halfword prefetch queue from word memory
// and presents 16/32-bit Thumb instructions to decode.
module cortex_m0_fetch
   import cortex_m0_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   cortex_m0_fetch_if.master bus,
   output fetch_state_e      state
);

   localparam logic [31:0] RESET_HEAD  = RESET_PC & ~32'd1;
   localparam logic [31:0] RESET_FETCH = RESET_PC & ~32'd3;

   logic [2:0]  count;
   logic [2:0]  count_next;
   logic [15:0] head;
   logic [15:0] head_next;
   logic [15:0] push_lo;
   logic [1:0]  push_n;
   logic [1:0]  pop_n;
   logic        head_is32;
   logic        inst_ok;
   logic        take;
   logic        hold;
   logic        req_q;
   logic        skip_low;
   logic [31:0] req_addr;
   logic [31:0] fetch_addr;
   logic [31:0] fetch_addr_n;
   logic [31:0] head_pc;

   cortex_m0_fetch_queue u_queue (
      .clk       (clk),
      .reset     (reset),
      .flush     (bus.branch_valid),
      .push_n    (push_n),
      .push_lo   (push_lo),
      .push_hi   (bus.imem_rdata[31:16]),
      .pop_n     (pop_n),
      .count     (count),
      .head      (head),
      .head_next (head_next)
   );

   always_comb begin
      head_is32 = is_thumb32(head);
      inst_ok   = head_is32 ? (count >= 3'd2) : (count != 3'd0);
      hold      = req_q && !bus.imem_ack;
      // Ack data is dropped in DISCARD or when a branch arrives in the same cycle.
      take      = req_q && bus.imem_ack && (state == FETCH) && !bus.branch_valid;
      push_n    = take ? (skip_low ? 2'd1 : 2'd2) : 2'd0;
      push_lo   = skip_low ? bus.imem_rdata[31:16] : bus.imem_rdata[15:0];
      pop_n     = (inst_ok && bus.dec_ready && !bus.branch_valid) ?
                  (head_is32 ? 2'd2 : 2'd1) : 2'd0;
      count_next = count + {1'b0, push_n} - {1'b0, pop_n};
      if (bus.branch_valid) fetch_addr_n = bus.branch_target & ~32'd3;
      else if (take)        fetch_addr_n = fetch_addr + 32'd4;
      else                  fetch_addr_n = fetch_addr;
   end

   assign bus.imem_req   = req_q;
   assign bus.imem_addr  = req_addr;
   assign bus.inst_valid = inst_ok;
   assign bus.inst_is32  = (count != 3'd0) && head_is32;
   assign bus.inst_pc    = head_pc;
   assign bus.inst       = !inst_ok  ? 32'h0 :
                           head_is32 ? {head, head_next} : {16'h0, head};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= FETCH;
         req_q      <= 1'b0;
         req_addr   <= RESET_FETCH;
         fetch_addr <= RESET_FETCH;
         head_pc    <= RESET_HEAD;
         skip_low   <= RESET_PC[1];
      end else begin
         fetch_addr <= fetch_addr_n;
         // The request address stays frozen until the ack. This covers the
         // case where a branch has already moved fetch_addr.
         if (!hold) req_addr <= fetch_addr_n;
         if (bus.branch_valid) begin
            state    <= hold ? DISCARD : FETCH;
            req_q    <= 1'b1;
            head_pc  <= bus.branch_target & ~32'd1;
            skip_low <= bus.branch_target[1];
         end else begin
            if (pop_n != 2'd0) head_pc <= head_pc + ((pop_n == 2'd2) ? 32'd4 : 32'd2);
            if (take) skip_low <= 1'b0;
            case (state)
               FETCH:   req_q <= hold || (count_next <= ISSUE_MAX);
               DISCARD: begin
                  req_q <= 1'b1;
                  if (!hold) state <= FETCH;
               end
            endcase
         end
      end
   end

endmodule
